// File: rtl/truth_table_sequencer_if.sv
// Host-side bundle for truth_table_sequencer: run control, golden table, verdict and log stream.
// The host drives start/expected; the sequencer drives everything else.
interface truth_table_sequencer_if #(
  parameter int N_IN = 2
);
  logic                 start;
  logic [2**N_IN-1:0]   expected;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [N_IN:0]        err_count;
  logic                 log_valid;
  logic [N_IN-1:0]      log_vec;
  logic                 log_out;
  logic                 log_exp;

  modport master (
    output start, expected,
    input  busy, done, pass, err_count, log_valid, log_vec, log_out, log_exp
  );

  modport slave (
    input  start, expected,
    output busy, done, pass, err_count, log_valid, log_vec, log_out, log_exp
  );
endinterface

// File: rtl/truth_table_sequencer.sv
// Steps a combinational gate through every input vector, waits SETTLE cycles per vector,
// samples dut_out against a latched golden table, logs each record and reports pass/fail.
module truth_table_sequencer #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_sequencer_if.slave bus,
  output logic [N_IN-1:0]       dut_in,
  input  logic                  dut_out
);

  localparam int              N_VEC      = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_IDX   = {N_IN{1'b1}};
  localparam logic [3:0]      CNT_RELOAD = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [N_VEC-1:0]  exp_q;
  logic [N_IN-1:0]   idx_q;
  logic [3:0]        cnt_q;
  logic [N_IN-1:0]   dut_in_q;
  logic [N_IN:0]     err_q, err_next;
  logic              busy_q, done_q, pass_q;
  logic              log_valid_q, log_out_q, log_exp_q;
  logic [N_IN-1:0]   log_vec_q;
  logic              exp_bit, mismatch, last, load;

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    exp_bit  = exp_q[idx_q];
    last     = (idx_q == LAST_IDX);
    load     = (state_q == S_IDLE) && bus.start;
    // Written as "match clears" so an unknown dut_out falls through as a mismatch.
    mismatch = 1'b1;
    if (dut_out == exp_bit) mismatch = 1'b0;
    err_next = err_q + (N_IN + 1)'(mismatch);

    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_WAIT;
      S_WAIT:   if (cnt_q == '0) state_d = S_SAMPLE;
      S_SAMPLE: state_d = last ? S_DONE : S_WAIT;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the golden table is not reset; it is only read after being loaded on a start edge.
  always_ff @(posedge clk) begin
    if (load) exp_q <= bus.expected;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      cnt_q       <= '0;
      dut_in_q    <= '0;
      err_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      log_valid_q <= 1'b0;
      log_vec_q   <= '0;
      log_out_q   <= 1'b0;
      log_exp_q   <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      log_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            idx_q    <= '0;
            dut_in_q <= '0;
            err_q    <= '0;
            pass_q   <= 1'b0;
            cnt_q    <= CNT_RELOAD;
            busy_q   <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        S_SAMPLE: begin
          err_q       <= err_next;
          log_valid_q <= 1'b1;
          log_vec_q   <= idx_q;
          log_out_q   <= dut_out;
          log_exp_q   <= exp_bit;
          if (last) begin
            // Verdict includes this final sample, so it lines up with the done pulse.
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (err_next == '0);
          end else begin
            idx_q    <= idx_q + 1'b1;
            dut_in_q <= idx_q + 1'b1;
            cnt_q    <= CNT_RELOAD;
          end
        end
        default: ;
      endcase
    end
  end

  assign dut_in        = dut_in_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.log_valid = log_valid_q;
  assign bus.log_vec   = log_vec_q;
  assign bus.log_out   = log_out_q;
  assign bus.log_exp   = log_exp_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench: table of gate models and golden tables on a SETTLE=1 instance,
// plus hand sequences for reset mid-run, back-to-back runs and a SETTLE=3 instance.
module tb_truth_table_sequencer;

  logic       clk;
  logic       rst_n;
  logic [1:0] dut_in1, dut_in3;
  logic       dut_out1, dut_out3;
  logic       d1_1, d2_1, d1_3, d2_3;
  int         mode;
  int         checks;
  int         errors;

  truth_table_sequencer_if #(.N_IN(2)) if1 ();
  truth_table_sequencer_if #(.N_IN(2)) if3 ();

  truth_table_sequencer #(.N_IN(2), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave), .dut_in(dut_in1), .dut_out(dut_out1)
  );

  truth_table_sequencer #(.N_IN(2), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave), .dut_in(dut_in3), .dut_out(dut_out3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-cycle delay lines of OR(dut_in) model a slow gate.
  always_ff @(posedge clk) begin
    d1_1 <= |dut_in1;
    d2_1 <= d1_1;
    d1_3 <= |dut_in3;
    d2_3 <= d1_3;
  end
  assign dut_out3 = d2_3;

  // Gate models for the SETTLE=1 instance: 0 OR, 1 AND, 2 stuck-at-1, 3 NAND, 4 slow OR.
  always_comb begin
    case (mode)
      0:       dut_out1 = |dut_in1;
      1:       dut_out1 = &dut_in1;
      2:       dut_out1 = 1'b1;
      3:       dut_out1 = ~&dut_in1;
      4:       dut_out1 = d2_1;
      default: dut_out1 = 1'b0;
    endcase
  end

  typedef struct {
    string      name;
    int         mode;
    logic [3:0] exp_tab;
    logic [3:0] out_bits;
    int         err;
    logic       pass;
    int         repulse;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full run on the SETTLE=1 instance; repulse is the edge after which start is raised again.
  task automatic do_run(input vec_t v);
    int         nlog;
    int         ndone;
    int         done_edge;
    logic       pass_at_done;
    logic [3:0] ob;
    logic [3:0] et;
    nlog = 0; ndone = 0; done_edge = -1; pass_at_done = 1'b0;
    ob = v.out_bits; et = v.exp_tab;
    mode = v.mode;
    if1.expected = v.exp_tab;
    if1.start    = 1'b1;
    @(posedge clk); #1;
    if1.start    = 1'b0;
    if1.expected = ~v.exp_tab;
    check($sformatf("%s.busy_start", v.name), 32'(if1.busy), 1);
    check($sformatf("%s.err_clear", v.name), 32'(if1.err_count), 0);
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      check($sformatf("%s.dut_in@%0d", v.name, e), 32'(dut_in1), (e / 2 > 3) ? 3 : e / 2);
      if (if1.log_valid) begin
        if (nlog < 4) begin
          check($sformatf("%s.log_edge%0d", v.name, nlog), e, 2 * (nlog + 1));
          check($sformatf("%s.log_vec%0d", v.name, nlog), 32'(if1.log_vec), nlog);
          check($sformatf("%s.log_out%0d", v.name, nlog), 32'(if1.log_out), 32'(ob[nlog]));
          check($sformatf("%s.log_exp%0d", v.name, nlog), 32'(if1.log_exp), 32'(et[nlog]));
        end
        nlog++;
      end
      if (if1.done) begin
        ndone++;
        done_edge    = e;
        pass_at_done = if1.pass;
      end
      if1.start = (e == v.repulse);
    end
    check($sformatf("%s.log_count", v.name), nlog, 4);
    check($sformatf("%s.done_count", v.name), ndone, 1);
    check($sformatf("%s.done_edge", v.name), done_edge, 8);
    check($sformatf("%s.pass", v.name), 32'(pass_at_done), 32'(v.pass));
    check($sformatf("%s.pass_held", v.name), 32'(if1.pass), 32'(v.pass));
    check($sformatf("%s.err_count", v.name), 32'(if1.err_count), v.err);
    check($sformatf("%s.busy_end", v.name), 32'(if1.busy), 0);
  endtask

  vec_t tbl[7];

  initial begin
    int nlog;
    int ndone;
    int done_edge;
    checks = 0; errors = 0;
    mode = 0;
    rst_n = 1'b0;
    if1.start = 1'b0; if1.expected = '0;
    if3.start = 1'b0; if3.expected = '0;

    tbl[0] = '{"or",          0, 4'b1110, 4'b1110, 0, 1'b1, -1};
    tbl[1] = '{"and",         1, 4'b1110, 4'b1000, 2, 1'b0, -1};
    tbl[2] = '{"slow_s1",     4, 4'b1110, 4'b1101, 2, 1'b0, -1};
    tbl[3] = '{"restart_mid", 0, 4'b1110, 4'b1110, 0, 1'b1,  4};
    tbl[4] = '{"restart_dn",  3, 4'b0111, 4'b0111, 0, 1'b1,  8};
    tbl[5] = '{"or_vs_xor",   0, 4'b0110, 4'b1110, 1, 1'b0, -1};
    tbl[6] = '{"stuck1",      2, 4'b1110, 4'b1111, 1, 1'b0, -1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.dut_in", 32'(dut_in1), 0);
    check("rst.busy", 32'(if1.busy), 0);
    check("rst.done", 32'(if1.done), 0);
    check("rst.pass", 32'(if1.pass), 0);
    check("rst.err_count", 32'(if1.err_count), 0);
    check("rst.log", 32'({if1.log_valid, if1.log_vec, if1.log_out, if1.log_exp}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) do_run(tbl[i]);

    // Reset asserted during the WAIT of vector 2
    mode = 0; if1.expected = 4'b1110; if1.start = 1'b1;
    @(posedge clk); #1;
    if1.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rstmid.dut_in_before", 32'(dut_in1), 2);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid.dut_in", 32'(dut_in1), 0);
    check("rstmid.busy", 32'(if1.busy), 0);
    check("rstmid.err_count", 32'(if1.err_count), 0);
    ndone = 0;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk); #1;
      if (if1.done) ndone++;
    end
    check("rstmid.no_done", ndone, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_run(tbl[0]);

    // Back-to-back runs with start held high: stuck-at-1, then a correct OR
    mode = 2; if1.expected = 4'b1110; if1.start = 1'b1;
    @(posedge clk); #1;
    ndone = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (if1.done) ndone++;
      if (e == 8) begin
        check("b2b.done1", 32'(if1.done), 1);
        check("b2b.err1", 32'(if1.err_count), 1);
        check("b2b.pass1", 32'(if1.pass), 0);
        mode = 0;
      end
      if (e == 10) begin
        check("b2b.busy2", 32'(if1.busy), 1);
        check("b2b.err_cleared", 32'(if1.err_count), 0);
        check("b2b.pass_cleared", 32'(if1.pass), 0);
        if1.start = 1'b0;
      end
      if (e == 18) begin
        check("b2b.done2", 32'(if1.done), 1);
        check("b2b.err2", 32'(if1.err_count), 0);
        check("b2b.pass2", 32'(if1.pass), 1);
      end
    end
    check("b2b.done_count", ndone, 2);

    // SETTLE=3 against the slow OR gate
    if3.expected = 4'b1110; if3.start = 1'b1;
    @(posedge clk); #1;
    if3.start = 1'b0;
    nlog = 0; ndone = 0; done_edge = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (if3.log_valid) begin
        if (nlog < 4) begin
          check($sformatf("s3.log_edge%0d", nlog), e, 4 * (nlog + 1));
          check($sformatf("s3.log_out%0d", nlog), 32'(if3.log_out), (nlog == 0) ? 0 : 1);
        end
        nlog++;
      end
      if (if3.done) begin
        ndone++;
        done_edge = e;
      end
    end
    check("s3.log_count", nlog, 4);
    check("s3.done_count", ndone, 1);
    check("s3.done_edge", done_edge, 16);
    check("s3.pass", 32'(if3.pass), 1);
    check("s3.err_count", 32'(if3.err_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
